// File: rtl/btn_input_pkg.sv
// Shared defaults and helpers for the push-button input path.
// Board-level values target the 12 MHz clock and pull-up wired buttons.
package btn_input_pkg;

    localparam int BTN_COUNT_DEF       = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 120000;
    localparam bit ACTIVE_LOW_DEF      = 1'b1;

    typedef enum logic [1:0] {
        DB_AGREE,
        DB_COUNT,
        DB_FLIP
    } db_action_e;

    // A disagreement that has lasted DEBOUNCE_CYCLES-1 counted cycles flips the level.
    function automatic db_action_e db_action(input logic differs, input logic at_max);
        if (!differs) begin
            return DB_AGREE;
        end
        if (at_max) begin
            return DB_FLIP;
        end
        return DB_COUNT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: polarity fix, two-flop synchronizer, stability counter,
// debounced level flop and a combinational press pulse aligned with the level update.
module btn_debounce
    import btn_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_action_e       action;

    always_comb begin
        sync1_d = raw ^ ACTIVE_LOW;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press   = 1'b0;
        action  = db_action(sync2_q != level_q, cnt_q == CNT_MAX);
        case (action)
            DB_AGREE: cnt_d = '0;
            DB_COUNT: cnt_d = cnt_q + CNT_W'(1);
            DB_FLIP: begin
                level_d = sync2_q;
                // Pulse only on 0->1 so the event register sets on the same edge as the level.
                press   = sync2_q;
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/btn_input.sv
// BTN_COUNT debounced button channels plus sticky press flags that the CPU
// collects with a clear-on-read strobe.
module btn_input
    import btn_input_pkg::*;
#(
    parameter int BTN_COUNT       = BTN_COUNT_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_COUNT-1:0] btn_raw,
    input  logic                 rd_en,
    output logic [BTN_COUNT-1:0] btn_level,
    output logic [BTN_COUNT-1:0] btn_event,
    output logic                 event_pending,
    output logic [BTN_COUNT-1:0] rd_data
);

    logic [BTN_COUNT-1:0] press;
    logic [BTN_COUNT-1:0] event_q, event_d;
    logic [BTN_COUNT-1:0] rd_data_q, rd_data_d;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (press[i])
        );
    end

    // A press landing on the read edge is kept for the next read rather than folded into this one.
    always_comb begin
        event_d   = event_q | press;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = event_q;
            event_d   = press;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q   <= '0;
            rd_data_q <= '0;
        end else begin
            event_q   <= event_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign btn_event     = event_q;
    assign rd_data       = rd_data_q;
    assign event_pending = |event_q;

endmodule

// File: tb/tb_btn_input.sv
// Directed bench for btn_input with a 4-cycle debounce interval and active-low pins.
module tb_btn_input;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       rd_en;
    logic [4:0] btn_level;
    logic [4:0] btn_event;
    logic       event_pending;
    logic [4:0] rd_data;

    int vectors     = 0;
    int miscompares = 0;

    btn_input #(
        .BTN_COUNT       (5),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .rd_en         (rd_en),
        .btn_level     (btn_level),
        .btn_event     (btn_event),
        .event_pending (event_pending),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [4:0] lvl, input logic [4:0] evt,
                             input logic pend, input logic [4:0] rdd);
        check({tag, ".level"},   btn_level,             lvl);
        check({tag, ".event"},   btn_event,             evt);
        check({tag, ".pending"}, {4'b0, event_pending}, {4'b0, pend});
        check({tag, ".rd_data"}, rd_data,               rdd);
    endtask

    initial begin
        // 1. Reset with toggling pins, then release with nothing pressed
        rst_n   = 1'b0;
        rd_en   = 1'b0;
        btn_raw = 5'b11111;
        step(1);
        btn_raw = 5'b00000;
        step(2);
        btn_raw = 5'b01010;
        step(3);
        btn_raw = 5'b10101;
        step(2);
        check_all("reset_hold", 5'b00000, 5'b00000, 1'b0, 5'b00000);
        btn_raw = 5'b11111;
        step(1);
        rst_n = 1'b1;
        step(8);
        check_all("reset_release", 5'b00000, 5'b00000, 1'b0, 5'b00000);

        // 2. Clean press and release on bit 0: level flips at E0+5
        btn_raw = 5'b11110;
        step(5);
        check("press0_early.level", btn_level, 5'b00000);
        step(1);
        check_all("press0", 5'b00001, 5'b00001, 1'b1, 5'b00000);
        btn_raw = 5'b11111;
        step(5);
        check("release0_early.level", btn_level, 5'b00001);
        step(1);
        check_all("release0", 5'b00000, 5'b00001, 1'b1, 5'b00000);

        // 3. Bit 2 bounces with 3-cycle low pulses, then holds low
        for (int p = 0; p < 5; p++) begin
            btn_raw = 5'b11011;
            step(3);
            btn_raw = 5'b11111;
            step(2);
            check("bounce2.level", btn_level, 5'b00000);
        end
        btn_raw = 5'b11011;
        step(5);
        check("bounce2_hold_early.level", btn_level, 5'b00000);
        step(1);
        check_all("bounce2_hold", 5'b00100, 5'b00101, 1'b1, 5'b00000);

        // 4. Clear-on-read, then a read with nothing pending
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_all("read1", 5'b00100, 5'b00000, 1'b0, 5'b00101);
        step(3);
        check("read1_hold.rd_data", rd_data, 5'b00101);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_all("read2", 5'b00100, 5'b00000, 1'b0, 5'b00000);

        // 5. Bit 4 level rises on the same edge as rd_en while bit 1 is flagged
        btn_raw = 5'b11001;
        step(6);
        check_all("press1", 5'b00110, 5'b00010, 1'b1, 5'b00000);
        btn_raw = 5'b01001;
        step(5);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_all("collide", 5'b10110, 5'b10000, 1'b1, 5'b00010);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check_all("collide_next", 5'b10110, 5'b00000, 1'b0, 5'b10000);

        // 6. Reset while bit 1's counter sits at its final count
        btn_raw = 5'b11111;
        step(6);
        check("release_all.level", btn_level, 5'b00000);
        btn_raw = 5'b11101;
        step(5);
        rst_n = 1'b0;
        #1;
        check_all("mid_reset", 5'b00000, 5'b00000, 1'b0, 5'b00000);
        step(1);
        check("mid_reset_held.level", btn_level, 5'b00000);
        rst_n = 1'b1;
        step(5);
        check("after_reset_early.level", btn_level, 5'b00000);
        step(1);
        check_all("after_reset", 5'b00010, 5'b00010, 1'b1, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
